// File: rtl/lsu_mem_port.sv
// Load/store unit between execute and a word-addressed data memory.
// Converts byte addresses to word indices, extends load data and performs
// sub-word stores as a read-modify-write because the memory only writes whole words.
module lsu_mem_port #(
    parameter int ADDR_SHIFT = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic        o_read_cs,
    output logic        o_write_cs,
    output logic [31:0] o_address,
    output logic [31:0] o_memdat,
    input  logic [31:0] i_memdat
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LD    = 3'd1;
    localparam logic [2:0] ST_RD = 3'd2;
    localparam logic [2:0] ST_WR = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    logic [2:0]  state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] merge_q,  merge_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        fault_q,  fault_d;
    logic        req_fault;

    // Picks the addressed byte/half of a memory word and sign/zero-extends it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    load_extend = {{24{b[7]}}, b};
            3'd1:    load_extend = {{16{h[15]}}, h};
            3'd4:    load_extend = {24'd0, b};
            3'd5:    load_extend = {16'd0, h};
            default: load_extend = word;
        endcase
    endfunction

    // Replaces the addressed byte/half of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                                input logic [1:0] lane,
                                                input logic [31:0] old,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (f3)
            3'd0: begin
                case (lane)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            3'd1: begin
                if (lane[1]) r[31:16] = wd[15:0];
                else         r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        store_merge = r;
    endfunction

    // Classifies an incoming request as illegal or misaligned.
    always_comb begin
        req_fault = 1'b0;
        if (i_is_load == i_is_store)
            req_fault = 1'b1;
        if (i_is_load && (i_funct3 == 3'd3 || i_funct3 == 3'd6 || i_funct3 == 3'd7))
            req_fault = 1'b1;
        if (i_is_store && (i_funct3 > 3'd2))
            req_fault = 1'b1;
        if ((i_funct3[1:0] == 2'd1) && i_addr[0])
            req_fault = 1'b1;
        if ((i_funct3 == 3'd2) && (i_addr[1:0] != 2'd0))
            req_fault = 1'b1;
    end

    // Transaction sequencing: accept, memory access(es), one-cycle completion.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    addr_d   = i_addr;
                    wdata_d  = i_wdata;
                    funct3_d = i_funct3;
                    fault_d  = req_fault;
                    if (req_fault)             state_d = FIN;
                    else if (i_is_load)        state_d = LD;
                    else if (i_funct3 == 3'd2) state_d = ST_WR;
                    else                       state_d = ST_RD;
                end
            end
            LD: begin
                rdata_d = load_extend(funct3_q, addr_q[1:0], i_memdat);
                state_d = FIN;
            end
            ST_RD: begin
                merge_d = i_memdat;
                state_d = ST_WR;
            end
            ST_WR:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched request registers; reset clears everything.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // Memory-side strobes; selects are gated by reset so no write can slip through.
    always_comb begin
        o_read_cs  = rst && (state_q == LD || state_q == ST_RD);
        o_write_cs = rst && (state_q == ST_WR);
        o_address  = '0;
        o_memdat   = '0;
        if (state_q == LD || state_q == ST_RD || state_q == ST_WR)
            o_address = addr_q >> ADDR_SHIFT;
        if (state_q == ST_WR)
            o_memdat = store_merge(funct3_q, addr_q[1:0], merge_q, wdata_q);
    end

    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == FIN);
    assign o_fault = fault_q;
    assign o_rdata = rdata_q;

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit sitting between the execute stage and the word-addressed data memory.
- Takes one RV32I load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) per transaction and converts the byte address to a word index.
- Drives the memory's read/write chip-selects, and sign/zero-extends load data.
- The memory only writes whole words, so sub-word stores are done as a read-modify-write sequence.

Parameters:
- ADDR_SHIFT, 2, right-shift applied to the byte address to form the memory word index (o_address = addr >> ADDR_SHIFT).

Ports:
- clock  in  1  system clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_valid  in  1  request strobe from execute; sampled only when o_busy=0.
- i_is_load  in  1  request is a load.
- i_is_store  in  1  request is a store.
- i_funct3  in  3  RV32I funct3 (0=B, 1=H, 2=W, 4=BU, 5=HU).
- i_addr  in  32  byte address.
- i_wdata  in  32  store data (low byte/half used for SB/SH).
- o_busy  out  1  high whenever the FSM is not IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_fault  out  1  valid with o_done; misaligned or illegal request.
- o_rdata  out  32  extended load result; holds its value until the next successful load.
- o_read_cs  out  1  memory read select.
- o_write_cs  out  1  memory write select.
- o_address  out  32  memory word index.
- o_memdat  out  32  memory write data.
- i_memdat  in  32  memory read data; combinational, valid in the same cycle o_read_cs is high.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; o_rdata=0, o_fault=0, all latched request registers cleared.
  - o_read_cs and o_write_cs are forced 0 combinationally while rst=0, so no write occurs in a reset cycle, including mid-transaction.
- States: IDLE, LD, ST_RD, ST_WR, FIN.
- Memory-side outputs are combinational from state and latched registers, and are 0 outside the states listed below.
- o_address = addr_q >> ADDR_SHIFT in LD, ST_RD and ST_WR.
- IDLE, i_valid=1: latch addr, wdata, funct3, load/store; clear o_fault. Next state:
  - fault (see below) -> FIN with o_fault set;
  - load -> LD;
  - SW -> ST_WR;
  - SB/SH -> ST_RD.
- IDLE, i_valid=0: remain in IDLE.
- Fault conditions (no memory access is issued):
  - i_is_load and i_is_store both high, or both low with i_valid=1;
  - load funct3 in {3,6,7}; store funct3 greater than 2;
  - H/HU with addr[0]=1; W with addr[1:0] not 0.
- LD: o_read_cs=1. At the edge, capture the selected lane of i_memdat:
  - byte lane = addr[1:0], half lane = addr[1];
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Write the result to o_rdata; next state FIN.
- ST_RD: o_read_cs=1. Capture i_memdat into merge_q; next state ST_WR.
- ST_WR: o_write_cs=1.
  - SW: o_memdat = wdata.
  - SB: o_memdat = merge_q with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: o_memdat = merge_q with half lane addr[1] replaced by wdata[15:0].
  - Next state FIN.
- FIN: o_done=1 for exactly one cycle; next state IDLE. o_busy=0 again in the following cycle.
- i_valid while o_busy=1 is ignored; there is no queueing.
- Latency in cycles, counted from the accept edge to the o_done cycle:
  - fault: 1;
  - LW/LB/LH/LBU/LHU: 2;
  - SW: 2;
  - SB/SH: 3.
- Back-to-back throughput: a new request can be accepted in the cycle after FIN.
- Each write cycle asserts o_write_cs for exactly one clock.
- Stores never modify o_rdata. A faulted load leaves o_rdata unchanged.
- Little-endian lanes: byte 0 = bits [7:0].
- Addresses wrap modulo 2^32. No range checking; address decode (e.g. the LED word 0x402) belongs to the memory.

Test Plan:
- LW i_addr=0x10, memory word 4=0x8020A0F3 -> cycle1: o_read_cs=1, o_address=4; cycle2: o_done=1, o_fault=0, o_rdata=0x8020A0F3.
- Sub-word loads from word 4=0x8020A0F3:
  - LB 0x13 -> o_rdata=0xFFFFFF80; LBU 0x13 -> 0x00000080;
  - LH 0x12 -> 0xFFFF8020; LHU 0x12 -> 0x00008020;
  - LB 0x10 -> 0xFFFFFFF3.
- SB i_addr=0x11, i_wdata=0x000000AB, word 4=0x8020A0F3 -> cycle1 read of addr 4; cycle2 o_write_cs=1, o_memdat=0x8020ABF3; cycle3 o_done. Then SH 0x12, i_wdata=0x1234 -> written 0x1234ABF3.
- SW i_addr=0x1008, i_wdata=1 -> cycle1 o_write_cs=1, o_address=0x402, o_memdat=1; cycle2 o_done. Memory LED output goes high.
- LW i_addr=0x11 and SH i_addr=0x13 -> o_read_cs and o_write_cs never asserted; cycle1 o_done=1 with o_fault=1; o_rdata keeps its prior value. A following valid LW clears o_fault.
- Reset pulse (rst=0) during ST_RD of an SB -> o_write_cs stays 0 throughout; after the edge o_busy=0, o_rdata=0. Also: i_valid held high during a busy LD -> that extra request is not executed.
